// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among NREQ message senders.
// Optional idle-owner timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            last,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            ack,
  input  logic                       tx_full,
  output logic                       wr_uart,
  output logic [DATA_WIDTH-1:0]      w_data,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       timeout_err
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] owner_inc;
  logic          pick_valid;
  logic          xfer;
  logic          tmo_hit;
  int unsigned   idx;

  // First requester at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && req[idx[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[IW-1:0];
      end
    end
  end

  assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign xfer      = (state == LOCK) && req[owner] && !tx_full;
  assign wr_uart   = xfer;
  assign ack       = xfer ? (NREQ'(1) << owner) : '0;
  assign w_data    = (state == LOCK) ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign busy      = (state == LOCK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            state <= LOCK;
          end
        end
        LOCK: begin
          if ((xfer && last[owner]) || tmo_hit) begin
            state  <= IDLE;
            rr_ptr <= owner_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] timer;

  // Only cycles where the owner has withdrawn req count; tx_full stalls do not.
  assign tmo_hit = (state == LOCK) && !req[owner] && ((timer + 1'b1) == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (state == IDLE || xfer || tmo_hit) begin
        timer <= '0;
      end else if (!req[owner]) begin
        timer <= timer + 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, TIMEOUT=10).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(
    .NREQ       (4),
    .DATA_WIDTH (8),
    .TIMEOUT    (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .last        (last),
    .req_data    (req_data),
    .ack         (ack),
    .tx_full     (tx_full),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] d, input logic l);
    req[i]              = 1'b1;
    last[i]             = l;
    req_data[i*8 +: 8]  = d;
  endtask

  initial begin
    int exp_o;

    // Reset with everyone requesting
    reset = 1'b0; req = 4'hF; last = '0; req_data = '0; tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr",    32'(wr_uart), 32'h0);
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_tmo",   32'(timeout_err), 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_busy", 32'(busy), 32'h0);
    tick();
    chk("rel_owner", 32'(owner), 32'h0);
    chk("rel_busy1", 32'(busy), 32'h1);
    set_byte(0, 8'h10, 1'b1);
    #1;
    chk("r0_wdata", 32'(w_data), 32'h10);
    chk("r0_ack",   32'(ack), 32'h1);
    tick();
    req = '0; last = '0;
    #1;
    chk("r0_done", 32'(busy), 32'h0);

    // Single requester, three-byte message
    set_byte(2, 8'hA1, 1'b0);
    #1;
    chk("t2_arb_wr",  32'(wr_uart), 32'h0);
    chk("t2_arb_ack", 32'(ack), 32'h0);
    tick();
    chk("t2_owner", 32'(owner), 32'h2);
    chk("t2_wA1",   32'(w_data), 32'hA1);
    chk("t2_ackA1", 32'(ack), 32'h4);
    tick();
    set_byte(2, 8'hB2, 1'b0);
    #1;
    chk("t2_wB2",   32'(w_data), 32'hB2);
    chk("t2_ackB2", 32'(ack), 32'h4);
    tick();
    set_byte(2, 8'hC3, 1'b1);
    #1;
    chk("t2_wC3",  32'(w_data), 32'hC3);
    chk("t2_wrC3", 32'(wr_uart), 32'h1);
    tick();
    req = '0; last = '0;
    #1;
    chk("t2_busy", 32'(busy), 32'h0);

    // Round robin: all four send 2-byte messages; rr_ptr is 3 after the last test
    for (int i = 0; i < 4; i++) set_byte(i, 8'(i * 16), 1'b0);
    exp_o = 3;
    for (int m = 0; m < 6; m++) begin
      #1;
      chk("rr_idle_wr", 32'(wr_uart), 32'h0);
      tick();
      chk("rr_owner", 32'(owner), 32'(exp_o));
      for (int b = 0; b < 2; b++) begin
        set_byte(exp_o, 8'(exp_o * 16 + b), (b == 1));
        #1;
        chk("rr_wdata", 32'(w_data), 32'(exp_o * 16 + b));
        chk("rr_ack",   32'(ack), 32'(1 << exp_o));
        tick();
      end
      set_byte(exp_o, 8'(exp_o * 16), 1'b0);
      exp_o = (exp_o + 1) % 4;
    end

    // Backpressure on requester 1 (rr_ptr now 1)
    req = '0; last = '0;
    set_byte(1, 8'h51, 1'b0);
    tick();
    chk("bp_owner", 32'(owner), 32'h1);
    chk("bp_w51",   32'(w_data), 32'h51);
    tick();
    set_byte(1, 8'h52, 1'b0);
    tx_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_stall_wr",  32'(wr_uart), 32'h0);
      chk("bp_stall_ack", 32'(ack), 32'h0);
      chk("bp_hold_data", 32'(w_data), 32'h52);
      chk("bp_busy",      32'(busy), 32'h1);
      tick();
    end
    tx_full = 1'b0;
    #1;
    chk("bp_resume_wr",  32'(wr_uart), 32'h1);
    chk("bp_resume_w",   32'(w_data), 32'h52);
    chk("bp_resume_ack", 32'(ack), 32'h2);
    tick();
    set_byte(1, 8'h53, 1'b1);
    #1;
    chk("bp_w53", 32'(w_data), 32'h53);
    tick();
    req = '0; last = '0;

    // Wrap: rr_ptr=2 with req=1001 -> 3, then 0, then 3
    set_byte(3, 8'h3A, 1'b1);
    set_byte(0, 8'h0A, 1'b1);
    #1;
    chk("wr_idle", 32'(busy), 32'h0);
    tick();
    chk("wr_owner3", 32'(owner), 32'h3);
    chk("wr_w3A",    32'(w_data), 32'h3A);
    chk("wr_ack3",   32'(ack), 32'h8);
    tick();
    set_byte(3, 8'h3B, 1'b1);
    #1;
    chk("wr_gap_busy", 32'(busy), 32'h0);
    chk("wr_gap_wr",   32'(wr_uart), 32'h0);
    tick();
    chk("wr_owner0", 32'(owner), 32'h0);
    chk("wr_w0A",    32'(w_data), 32'h0A);
    chk("wr_ack0",   32'(ack), 32'h1);
    tick();
    set_byte(0, 8'h0B, 1'b1);
    tick();
    chk("wr_owner3b", 32'(owner), 32'h3);
    chk("wr_w3B",     32'(w_data), 32'h3B);
    chk("wr_ack3b",   32'(ack), 32'h8);
    tick();
    req = '0; last = '0;

    // Owner 1 withdraws after one byte while requester 2 waits
    set_byte(1, 8'h71, 1'b0);
    tick();
    chk("to_owner", 32'(owner), 32'h1);
    chk("to_ack",   32'(ack), 32'h2);
    tick();
    req = '0; last = '0;
    set_byte(2, 8'h81, 1'b1);
    for (int s = 0; s < 9; s++) begin
      #1;
      chk("to_wait_busy", 32'(busy), 32'h1);
      chk("to_wait_wr",   32'(wr_uart), 32'h0);
      chk("to_wait_err",  32'(timeout_err), 32'h0);
      tick();
    end
    chk("to_pre_busy", 32'(busy), 32'h1);
    chk("to_pre_err",  32'(timeout_err), 32'h0);
    tick();
`ifdef UART_ARB_TIMEOUT_EN
    chk("to_err_pulse", 32'(timeout_err), 32'h1);
    chk("to_released",  32'(busy), 32'h0);
    tick();
    chk("to_err_clear", 32'(timeout_err), 32'h0);
    chk("to_owner2",    32'(owner), 32'h2);
    chk("to_w81",       32'(w_data), 32'h81);
    chk("to_ack2",      32'(ack), 32'h4);
    tick();
    chk("to_done", 32'(busy), 32'h0);
`else
    chk("nt_err",   32'(timeout_err), 32'h0);
    chk("nt_busy",  32'(busy), 32'h1);
    tick();
    chk("nt_owner", 32'(owner), 32'h1);
    chk("nt_busy2", 32'(busy), 32'h1);
    set_byte(1, 8'h72, 1'b1);
    #1;
    chk("nt_ack1", 32'(ack), 32'h2);
    chk("nt_w72",  32'(w_data), 32'h72);
    tick();
    chk("nt_done", 32'(busy), 32'h0);
`endif
    req = '0; last = '0;

    // Asynchronous reset abandons a message in progress
    set_byte(0, 8'h99, 1'b0);
    tick();
    chk("ar_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    chk("ar_busy0", 32'(busy), 32'h0);
    chk("ar_wr0",   32'(wr_uart), 32'h0);
    chk("ar_wdata", 32'(w_data), 32'h0);
    chk("ar_owner", 32'(owner), 32'h0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter FIFO write port (wr_uart / w_data / tx_full) among NREQ independent requesters. Each requester sends a multi-byte message. The grant stays locked to one requester until that requester's last byte is accepted, so messages are never interleaved on the serial line. The block sits between on-chip clients and the UART transmitter/receiver pair, driving its write side.

Parameters:
NREQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, byte width; must match the UART data width
IW, $clog2(NREQ), owner index width (localparam)
TIMEOUT, 255, idle-owner cycles before forced release (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
req  in  NREQ  per-requester byte valid
last  in  NREQ  per-requester "this byte ends the message", qualified by req
req_data  in  NREQ*DATA_WIDTH  flattened bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NREQ  one-hot byte accepted for requester i
tx_full  in  1  UART transmit FIFO full
wr_uart  out  1  write strobe to UART transmit FIFO
w_data  out  DATA_WIDTH  byte to UART transmit FIFO
busy  out  1  high while a message is locked
owner  out  IW  index of the current or last owner
timeout_err  out  1  one-cycle pulse on forced release (tied 0 without the macro)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, busy=0, timeout_err=0, internal timer=0.
  - ack, wr_uart and w_data are 0 because state is IDLE.
- States: IDLE and LOCK. busy = (state==LOCK), registered.
- IDLE arbitration:
  - If any req bit is high, select the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap at NREQ-1 -> 0.
  - Register owner=i and go to LOCK.
  - This arbitration cycle transfers no byte. If no req bit is high, stay in IDLE.
- LOCK transfer:
  - xfer = req[owner] & ~tx_full. This is combinational.
  - wr_uart = xfer. ack[owner] = xfer. All other ack bits are 0.
  - w_data = req_data slice of owner when in LOCK, else 0.
- Handshake rules:
  - A requester holds req, req_data and last stable until it sees ack. Its next byte may follow in the next cycle.
  - Steady-state throughput is 1 byte/clk. A message of L bytes takes at least L+1 cycles including arbitration.
- Release:
  - When xfer & last[owner]: go to IDLE and set rr_ptr = (owner==NREQ-1) ? 0 : owner+1.
  - A single-byte message (last on its first byte) is legal.
- Stall behaviour:
  - While tx_full=1, wr_uart is never asserted, no ack is issued, and the state is held.
  - Owner deasserting req mid-message: remain in LOCK with no transfer. Without the macro, the lock persists indefinitely.
- Other requesters:
  - req from non-owners is ignored during LOCK. It competes at the next IDLE cycle.
  - After release, IDLE always spends one cycle before any new grant, including a re-grant to the same requester.
- Reset asserted mid-message: the message is abandoned. Bytes already written to the FIFO stay; there is no recovery.

Optional Feature:
Macro: UART_ARB_TIMEOUT_EN
- Defined:
  - An 8+ bit timer clears on entry to LOCK and on every xfer.
  - The timer increments each LOCK cycle with req[owner]=0. Cycles stalled by tx_full with req[owner]=1 do not count.
  - When the timer reaches TIMEOUT: go to IDLE, advance rr_ptr past owner, and pulse timeout_err for exactly 1 cycle.
- Not defined: no timer exists, timeout_err is constant 0, and the lock never expires.

Test Plan:
1. Reset: hold reset=0 with req=4'b1111 -> wr_uart=0, ack=0, busy=0, owner=0. Release reset -> grant to 0 one cycle later.
2. Single requester: req[2] sends 0xA1, 0xB2, 0xC3 (last on 0xC3), tx_full=0 -> w_data sequence A1/B2/C3 on 3 consecutive cycles, ack[2] each cycle, then busy=0 and rr_ptr=3.
3. Round-robin fairness: all four requesters send 2-byte messages continuously -> owner order 0, 1, 2, 3, 0. No interleaving of bytes within a message.
4. Backpressure: tx_full=1 for 5 cycles mid-message of requester 1 -> no wr_uart or ack during the stall, byte held. Transfer resumes on the cycle tx_full drops, with no byte lost or duplicated.
5. Wrap and priority: owner 3 finishes while req=4'b1001 -> next owner 0. Then with req=4'b1001 again -> next owner 3.
6. With UART_ARB_TIMEOUT_EN and TIMEOUT=10: owner 1 drops req after 1 byte -> after 10 idle cycles timeout_err=1 for 1 cycle, busy=0, and waiting requester 2 is granted next.
